// File: rtl/mdc_secuenciador_preparacion.sv
// Brew sequencer: supply check, heat, grind, brew, drip-out, fault report.
// Define MDC_CONTADOR_TAZAS_EN to add the saturating served-cups counter.
module mdc_secuenciador_preparacion #(
  parameter int CNT_W        = 8,
  parameter int HEAT_TIMEOUT = 64,
  parameter int GRIND_CYCLES = 8,
  parameter int BREW_CAFE    = 16,
  parameter int BREW_OTRO    = 12,
  parameter int DRIP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel,
  input  logic       ha,
  input  logic       hc,
  input  logic       temp_ok,
  input  logic       abort,
  input  logic       fault_clr,
  output logic       heater_en,
  output logic       grinder_en,
  output logic       pump_en,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
`ifdef MDC_CONTADOR_TAZAS_EN
  ,
  output logic [15:0] tazas
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_HEAT,
    S_GRIND,
    S_BREW,
    S_DRIP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_WATER = 2'b01;
  localparam logic [1:0] C_CAFE  = 2'b10;
  localparam logic [1:0] C_HEAT  = 2'b11;

  localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GRIND_LAST = CNT_W'(GRIND_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAFE_LAST  = CNT_W'(BREW_CAFE - 1);
  localparam logic [CNT_W-1:0] OTRO_LAST  = CNT_W'(BREW_OTRO - 1);
  localparam logic [CNT_W-1:0] DRIP_LAST  = CNT_W'(DRIP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           st;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             sel_q;
  logic [1:0]       code_nxt;
  logic [CNT_W-1:0] brew_last;
  logic             timed;

  assign brew_last = sel_q ? OTRO_LAST : CAFE_LAST;

  // Only the timed phases advance the counter.
  assign timed = (st == S_HEAT) || (st == S_GRIND) ||
                 (st == S_BREW) || (st == S_DRIP);

  always_comb begin
    nxt      = st;
    code_nxt = fault_code;
    unique case (st)
      S_IDLE: begin
        if (start) nxt = S_CHECK;
      end
      S_CHECK: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (!ha) begin
          nxt      = S_FAULT;
          code_nxt = C_WATER;
        end else if (!sel_q && !hc) begin
          nxt      = S_FAULT;
          code_nxt = C_CAFE;
        end else begin
          nxt = S_HEAT;
        end
      end
      S_HEAT: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (temp_ok) begin
          nxt = sel_q ? S_BREW : S_GRIND;
        end else if (cnt == HEAT_LAST) begin
          nxt      = S_FAULT;
          code_nxt = C_HEAT;
        end
      end
      S_GRIND: begin
        if (abort) nxt = S_IDLE;
        else if (cnt == GRIND_LAST) nxt = S_BREW;
      end
      S_BREW: begin
        // Losing water mid-brew outranks the end of the pump phase.
        if (abort) begin
          nxt = S_IDLE;
        end else if (!ha) begin
          nxt      = S_FAULT;
          code_nxt = C_WATER;
        end else if (cnt == brew_last) begin
          nxt = S_DRIP;
        end
      end
      S_DRIP: begin
        if (abort) nxt = S_IDLE;
        else if (cnt == DRIP_LAST) nxt = S_DONE;
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) begin
          nxt      = S_IDLE;
          code_nxt = C_NONE;
        end
      end
      default: begin
        nxt      = S_IDLE;
        code_nxt = C_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= S_IDLE;
      cnt        <= '0;
      sel_q      <= 1'b0;
      heater_en  <= 1'b0;
      grinder_en <= 1'b0;
      pump_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= C_NONE;
    end else begin
      st <= nxt;
      if (nxt != st) cnt <= '0;
      else if (timed && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (st == S_IDLE && start) sel_q <= sel;
      heater_en  <= (nxt == S_HEAT) || (nxt == S_GRIND) ||
                    (nxt == S_BREW);
      grinder_en <= (nxt == S_GRIND);
      pump_en    <= (nxt == S_BREW);
      busy       <= (nxt != S_IDLE) && (nxt != S_FAULT);
      done       <= (nxt == S_DONE);
      fault      <= (nxt == S_FAULT);
      fault_code <= code_nxt;
    end
  end

`ifdef MDC_CONTADOR_TAZAS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tazas <= '0;
    end else if (nxt == S_DONE && st != S_DONE && tazas != 16'hFFFF) begin
      tazas <= tazas + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdc_secuenciador_preparacion.sv
// Bench for the brew sequencer: directed scenarios plus random
// stimulus, all checked each cycle against a phase-level reference model.
module tb_mdc_secuenciador_preparacion;

  localparam int HT = 64;
  localparam int GC = 8;
  localparam int BC = 16;
  localparam int BO = 12;
  localparam int DC = 4;

  localparam int P_IDLE  = 0;
  localparam int P_CHECK = 1;
  localparam int P_HEAT  = 2;
  localparam int P_GRIND = 3;
  localparam int P_BREW  = 4;
  localparam int P_DRIP  = 5;
  localparam int P_DONE  = 6;
  localparam int P_FAULT = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic ha = 1'b1;
  logic hc = 1'b1;
  logic temp_ok = 1'b0;
  logic abort = 1'b0;
  logic fault_clr = 1'b0;
  logic heater_en, grinder_en, pump_en, busy, done, fault;
  logic [1:0] fault_code;
`ifdef MDC_CONTADOR_TAZAS_EN
  logic [15:0] tazas;
`endif

  mdc_secuenciador_preparacion dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sel(sel),
    .ha(ha),
    .hc(hc),
    .temp_ok(temp_ok),
    .abort(abort),
    .fault_clr(fault_clr),
    .heater_en(heater_en),
    .grinder_en(grinder_en),
    .pump_en(pump_en),
    .busy(busy),
    .done(done),
    .fault(fault),
    .fault_code(fault_code)
`ifdef MDC_CONTADOR_TAZAS_EN
    ,
    .tazas(tazas)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int ph = P_IDLE;
  int left = 0;
  bit msel = 1'b0;
  logic [1:0] mcode = 2'b00;
  int mtazas = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase model: each timed phase counts remaining cycles down to 1.
  task automatic model_step();
    if (!rst) begin
      ph = P_IDLE;
      mcode = 2'b00;
      msel = 1'b0;
      mtazas = 0;
    end else begin
      case (ph)
        P_IDLE: if (start) begin msel = sel; ph = P_CHECK; end
        P_CHECK:
          if (abort) ph = P_IDLE;
          else if (!ha) begin ph = P_FAULT; mcode = 2'b01; end
          else if (!msel && !hc) begin ph = P_FAULT; mcode = 2'b10; end
          else begin ph = P_HEAT; left = HT; end
        P_HEAT:
          if (abort) ph = P_IDLE;
          else if (temp_ok) begin
            if (msel) begin ph = P_BREW; left = BO; end
            else begin ph = P_GRIND; left = GC; end
          end else if (left == 1) begin ph = P_FAULT; mcode = 2'b11; end
          else left--;
        P_GRIND:
          if (abort) ph = P_IDLE;
          else if (left == 1) begin ph = P_BREW; left = BC; end
          else left--;
        P_BREW:
          if (abort) ph = P_IDLE;
          else if (!ha) begin ph = P_FAULT; mcode = 2'b01; end
          else if (left == 1) begin ph = P_DRIP; left = DC; end
          else left--;
        P_DRIP:
          if (abort) ph = P_IDLE;
          else if (left == 1) begin
            ph = P_DONE;
            if (mtazas < 65535) mtazas++;
          end else left--;
        P_DONE: ph = P_IDLE;
        default: if (fault_clr) begin ph = P_IDLE; mcode = 2'b00; end
      endcase
    end
  endtask

  task automatic compare_all();
    chk("heater_en", 32'(heater_en),
        32'(ph == P_HEAT || ph == P_GRIND || ph == P_BREW));
    chk("grinder_en", 32'(grinder_en), 32'(ph == P_GRIND));
    chk("pump_en", 32'(pump_en), 32'(ph == P_BREW));
    chk("busy", 32'(busy), 32'(ph != P_IDLE && ph != P_FAULT));
    chk("done", 32'(done), 32'(ph == P_DONE));
    chk("fault", 32'(fault), 32'(ph == P_FAULT));
    chk("fault_code", 32'(fault_code), 32'(mcode));
`ifdef MDC_CONTADOR_TAZAS_EN
    chk("tazas", 32'(tazas), 32'(mtazas));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; fault_clr = 0; rst = 1;
  endtask

  // Serve from IDLE; reports edges to done and actuator cycle counts.
  task automatic serve(input logic s, output int lat,
                       output int ng, output int np);
    lat = -1; ng = 0; np = 0;
    start = 1; sel = s;
    tick();
    start = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (grinder_en) ng++;
      if (pump_en) np++;
      if (done && lat < 0) lat = i;
    end
  endtask

  int lat, ng, np, nh;

  initial begin
    rst = 0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_code", 32'(fault_code), 32'd0);
    idle_inputs();

    // Coffee serve timing
    ha = 1; hc = 1; temp_ok = 1;
    serve(1'b0, lat, ng, np);
    chk("cafe_done_edge", 32'(lat), 32'd30);
    chk("cafe_grind_cycles", 32'(ng), 32'd8);
    chk("cafe_pump_cycles", 32'(np), 32'd16);
    chk("cafe_busy_after", 32'(busy), 32'd0);

    // Other beverage with no coffee: hc is not checked
    hc = 0;
    serve(1'b1, lat, ng, np);
    chk("otro_done_edge", 32'(lat), 32'd18);
    chk("otro_grind_cycles", 32'(ng), 32'd0);
    chk("otro_pump_cycles", 32'(np), 32'd12);
    hc = 1;

    // No water at start
    ha = 0;
    start = 1; sel = 0; tick(); start = 0;
    tick();
    chk("nowater_fault", 32'(fault), 32'd1);
    chk("nowater_code", 32'(fault_code), 32'd1);
    start = 1; tick(); start = 0;
    chk("fault_ignores_start", 32'(fault), 32'd1);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code", 32'(fault_code), 32'd0);
    ha = 1;

    // Heat timeout
    temp_ok = 0; nh = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (heater_en) nh++;
    end
    chk("heat_cycles", 32'(nh), 32'd64);
    chk("heat_code", 32'(fault_code), 32'd3);
    fault_clr = 1; tick(); fault_clr = 0;

    // temp_ok rises on the last HEAT cycle
    start = 1; tick(); start = 0;
    for (int i = 0; i < 80 && ph != P_GRIND; i++) begin
      temp_ok = (ph == P_HEAT && left == 1);
      tick();
    end
    chk("heat_last_grind", 32'(grinder_en), 32'd1);
    chk("heat_last_nofault", 32'(fault), 32'd0);
    abort = 1; tick(); abort = 0;
    temp_ok = 1;

    // Abort on the 5th BREW cycle
    start = 1; sel = 0; tick(); start = 0;
    for (int i = 0; i < 40 && !(ph == P_BREW && left == BC - 4); i++)
      tick();
    abort = 1; tick(); abort = 0;
    chk("abort_pump", 32'(pump_en), 32'd0);
    chk("abort_heater", 32'(heater_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    serve(1'b0, lat, ng, np);
    chk("after_abort_done", 32'(lat), 32'd30);

    // Reset in GRIND
    start = 1; tick(); start = 0;
    for (int i = 0; i < 10 && ph != P_GRIND; i++) tick();
    rst = 0; tick(); rst = 1;
    chk("rst_grind_heater", 32'(heater_en), 32'd0);
    chk("rst_grind_busy", 32'(busy), 32'd0);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) != 0);
      start = ($urandom_range(0, 3) == 0);
      sel = 1'($urandom_range(0, 1));
      ha = ($urandom_range(0, 29) != 0);
      hc = ($urandom_range(0, 9) != 0);
      temp_ok = ($urandom_range(0, 4) == 0);
      abort = ($urandom_range(0, 59) == 0);
      fault_clr = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdc_secuenciador_preparacion.md
Name: mdc_secuenciador_preparacion

Overview:
- Brew sequencer for the coffee machine.
- Once the main coin/selection FSM authorises a serve, this block runs the physical preparation: check supplies, heat, grind (coffee only), pump/brew, drip-out.
- It owns the timing counters and the fault detection, and reports completion or a fault back to the main FSM.
- Moore-style controller with registered outputs, one clock domain.

Parameters:
- CNT_W, 8, counter width in bits.
- HEAT_TIMEOUT, 64, max cycles in HEAT waiting for temp_ok before fault.
- GRIND_CYCLES, 8, cycles in GRIND.
- BREW_CAFE, 16, pump cycles for coffee (sel=0).
- BREW_OTRO, 12, pump cycles for other beverage (sel=1).
- DRIP_CYCLES, 4, idle drip-out cycles before done.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  serve request from main FSM, sampled only in IDLE.
- sel  input  1  beverage select, latched at start: 0 = coffee, 1 = other.
- ha  input  1  water present.
- hc  input  1  coffee present.
- temp_ok  input  1  boiler at temperature.
- abort  input  1  cancel current preparation.
- fault_clr  input  1  acknowledge/clear fault.
- heater_en  output  1  boiler heater on.
- grinder_en  output  1  grinder on.
- pump_en  output  1  water pump on.
- busy  output  1  high in any state except IDLE and FAULT.
- done  output  1  one-cycle completion pulse.
- fault  output  1  fault latched.
- fault_code  output  2  00 none, 01 no water, 10 no coffee, 11 heat timeout.

Behaviour:
- Reset: rst=0 at a clock edge forces state IDLE, counter 0, sel_q 0, and all outputs 0 (including fault_code=00). Reset applies mid-operation with no done and no fault.
- Outputs are registered and decoded from the next state, so they take their new values on the same edge as the state change.
- States:
  - IDLE: all outputs 0. start=1 latches sel into sel_q, clears the counter, and moves to CHECK. Otherwise stay.
  - CHECK (1 cycle): if ha=0 go to FAULT with code 01. Else if sel_q=0 and hc=0 go to FAULT with code 10. Else go to HEAT. Water is checked before coffee.
  - HEAT: heater_en=1; counter increments each cycle.
    - temp_ok=1 with sel_q=0 goes to GRIND; with sel_q=1 goes to BREW.
    - If the counter reaches HEAT_TIMEOUT-1 with temp_ok=0, go to FAULT with code 11. temp_ok wins if both happen in the same cycle.
  - GRIND: grinder_en=1, heater_en=1 for exactly GRIND_CYCLES cycles, then BREW.
  - BREW: pump_en=1, heater_en=1 for BREW_CAFE or BREW_OTRO cycles (chosen by sel_q), then DRIP. ha=0 during BREW goes to FAULT with code 01 immediately.
  - DRIP: all actuators off for DRIP_CYCLES cycles, then DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - FAULT: fault=1 and fault_code held, actuators off. fault_clr=1 goes to IDLE, clearing fault and fault_code. start is ignored here.
- The counter clears on every state change and is never allowed to wrap; the terminal compare fires at value N-1.
- abort=1 in CHECK/HEAT/GRIND/BREW/DRIP returns to IDLE next edge: actuators off, no done, no fault. abort has priority over every other transition except reset. abort is ignored in IDLE, DONE and FAULT.
- start while not IDLE is ignored and not queued.
- Timing: with start sampled at edge N (coffee, supplies ok, temp_ok already high):
  - CHECK from N, HEAT from N+1, GRIND from N+2, BREW from N+10, DRIP from N+26, DONE from N+30.
  - done is high between edges N+30 and N+31.
- Other beverage, same conditions: BREW from N+2, DRIP from N+14, DONE from N+18.

Optional Feature:
- MDC_CONTADOR_TAZAS_EN defined: adds output tazas [15:0], a count of completed serves.
  - Increments on each DONE entry and saturates at 16'hFFFF.
  - Cleared by reset only; not cleared by abort, fault or fault_clr.
- MDC_CONTADOR_TAZAS_EN undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Coffee, ha=hc=temp_ok=1, start pulse at edge N -> grinder_en high for 8 cycles from N+2, pump_en high for 16 cycles from N+10, done single pulse after edge N+30, busy low after DONE.
- sel=1, hc=0, ha=temp_ok=1 -> no grinding (hc not checked), pump_en high for 12 cycles from N+2, done after edge N+18.
- ha=0 at start -> FAULT at N+1, fault_code=01, no actuator ever high; fault_clr=1 -> IDLE, fault=0, fault_code=00.
- temp_ok held 0 -> heater_en high for 64 cycles, then fault=1 with fault_code=11; repeat with temp_ok rising exactly on the 64th HEAT cycle -> GRIND, no fault.
- abort=1 on the 5th BREW cycle -> pump_en and heater_en low next edge, state IDLE, no done, no fault; a new start is then accepted normally.
- rst=0 asserted during GRIND -> all outputs 0 on the next edge. With MDC_CONTADOR_TAZAS_EN defined: 3 completed serves -> tazas=3; an aborted serve leaves tazas unchanged.
